// File: rtl/exec_decode_stage_if.sv
// Bundle handshake between the fetch/regfile-read stage, the decode stage and the exec units.
// master = upstream/downstream environment side, slave = decode stage side.
interface exec_decode_stage_if #(
    parameter int NUM_LANES = 1
);
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_LANES-1:0]     in_lane_valid;
    logic [7*NUM_LANES-1:0]   in_opcode;
    logic [3*NUM_LANES-1:0]   in_funct3;
    logic [7*NUM_LANES-1:0]   in_funct7;

    logic                     out_valid;
    logic                     out_ready;
    logic [NUM_LANES-1:0]     out_lane_valid;
    logic [4*NUM_LANES-1:0]   out_exec_op;
    logic [NUM_LANES-1:0]     out_op1_sel;
    logic [NUM_LANES-1:0]     out_op2_sel;
    logic [NUM_LANES-1:0]     out_muldiv;
    logic [NUM_LANES-1:0]     out_illegal;

    modport master (
        output in_valid, in_lane_valid, in_opcode, in_funct3, in_funct7, out_ready,
        input  in_ready, out_valid, out_lane_valid, out_exec_op, out_op1_sel,
               out_op2_sel, out_muldiv, out_illegal
    );

    modport slave (
        input  in_valid, in_lane_valid, in_opcode, in_funct3, in_funct7, out_ready,
        output in_ready, out_valid, out_lane_valid, out_exec_op, out_op1_sel,
               out_op2_sel, out_muldiv, out_illegal
    );
endinterface

// File: rtl/exec_decode_stage.sv
// Registered multi-lane exec decoder: per-lane opcode/funct decode, output register
// plus one skid entry behind a valid/ready handshake, flush, saturating illegal counter.
module exec_decode_stage #(
    parameter int NUM_LANES = 1,
    parameter int ENABLE_M  = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    exec_decode_stage_if.slave   bus,
    output logic [CNT_W-1:0]     illegal_count
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [CNT_W+2:0] CNT_MAX = {3'b000, {CNT_W{1'b1}}};

    typedef struct packed {
        logic [NUM_LANES-1:0]      lv;
        logic [NUM_LANES-1:0][3:0] op;
        logic [NUM_LANES-1:0]      op1;
        logic [NUM_LANES-1:0]      op2;
        logic [NUM_LANES-1:0]      md;
        logic [NUM_LANES-1:0]      ill;
    } bundle_t;

    bundle_t          dec;
    bundle_t          out_q, out_d, skid_q, skid_d;
    logic             out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, out_free;
    logic [2:0]       pop;
    logic [CNT_W+2:0] sum;

    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [3:0] l_op;
    logic       l_op1, l_op2, l_md, l_ill;

    // Per-lane decode of the incoming bundle; invalid lanes decode to all zeros.
    always_comb begin
        dec   = '0;
        opc   = '0;
        f3    = '0;
        f7    = '0;
        l_op  = '0;
        l_op1 = 1'b0;
        l_op2 = 1'b0;
        l_md  = 1'b0;
        l_ill = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            opc   = bus.in_opcode[7*i +: 7];
            f3    = bus.in_funct3[3*i +: 3];
            f7    = bus.in_funct7[7*i +: 7];
            l_op  = 4'b0000;
            l_op1 = 1'b0;
            l_op2 = 1'b1;
            l_md  = 1'b0;
            l_ill = 1'b0;
            case (opc)
                OPC_OP: begin
                    l_op2 = 1'b0;
                    if (f7 == 7'b0000000)
                        l_op = {1'b0, f3};
                    else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                        l_op = {1'b1, f3};
                    else if (f7 == 7'b0000001 && ENABLE_M != 0) begin
                        l_op = {1'b0, f3};
                        l_md = 1'b1;
                    end else
                        l_ill = 1'b1;
                end
                OPC_OP_IMM: begin
                    // funct7 is immediate bits except for the shift encodings
                    l_op = {1'b0, f3};
                    if (f3 == 3'b001)
                        l_ill = (f7 != 7'b0000000);
                    else if (f3 == 3'b101) begin
                        if (f7 == 7'b0100000)
                            l_op = 4'b1101;
                        else if (f7 != 7'b0000000)
                            l_ill = 1'b1;
                    end
                end
                OPC_BRANCH, OPC_JAL, OPC_AUIPC: l_op1 = 1'b1;
                default: ;
            endcase
            if (l_ill) begin
                l_op = 4'b0000;
                l_md = 1'b0;
            end
            if (bus.in_lane_valid[i]) begin
                dec.lv[i]  = 1'b1;
                dec.op[i]  = l_op;
                dec.op1[i] = l_op1;
                dec.op2[i] = l_op2;
                dec.md[i]  = l_md;
                dec.ill[i] = l_ill;
            end
        end
    end

    // Output register + skid steering; flush wins over accept and the skid move.
    always_comb begin
        accept     = bus.in_valid & ~skid_vld_q & ~flush;
        out_free   = ~out_vld_q | bus.out_ready;
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (out_free) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                out_d     = dec;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = dec;
            skid_vld_d = 1'b1;
        end
    end

    // Saturating count of illegal valid lanes in accepted bundles.
    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_LANES; i++)
            pop = pop + {2'b00, dec.ill[i]};
        sum   = {3'b000, cnt_q} + {{CNT_W{1'b0}}, pop};
        cnt_d = cnt_q;
        if (accept)
            cnt_d = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.in_ready       = ~skid_vld_q;
    assign bus.out_valid      = out_vld_q;
    assign bus.out_lane_valid = out_q.lv;
    assign bus.out_exec_op    = out_q.op;
    assign bus.out_op1_sel    = out_q.op1;
    assign bus.out_op2_sel    = out_q.op2;
    assign bus.out_muldiv     = out_q.md;
    assign bus.out_illegal    = out_q.ill;
    assign illegal_count      = cnt_q;
endmodule

// File: tb/tb_exec_decode_stage.sv
// Scoreboard bench: DUT A (1 lane, M enabled, 16-bit counter) and
// DUT B (2 lanes, M disabled, 2-bit counter) driven with directed bundles.
module tb_exec_decode_stage;
    typedef struct packed {
        logic [1:0] lv;
        logic [7:0] op;
        logic [1:0] o1, o2, md, ill;
    } exp_t;

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] IMM = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] AUI = 7'b0010111;
    localparam logic [6:0] LD  = 7'b0000011;

    logic        clk = 1'b0, reset_n = 1'b0, flush_a = 1'b0, flush_b = 1'b0;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;
    int          tests = 0, fails = 0;
    exp_t        qa[$], qb[$];

    always #5 clk = ~clk;

    exec_decode_stage_if #(.NUM_LANES(1)) ifa();
    exec_decode_stage_if #(.NUM_LANES(2)) ifb();

    exec_decode_stage #(.NUM_LANES(1), .ENABLE_M(1), .CNT_W(16)) u_a (
        .clk(clk), .reset_n(reset_n), .flush(flush_a), .bus(ifa), .illegal_count(cnt_a));
    exec_decode_stage #(.NUM_LANES(2), .ENABLE_M(0), .CNT_W(2)) u_b (
        .clk(clk), .reset_n(reset_n), .flush(flush_b), .bus(ifb), .illegal_count(cnt_b));

    function automatic exp_t mk(input int lv, input int op, input int o1, input int o2,
                                input int md, input int ill);
        exp_t e;
        e.lv = 2'(lv); e.op = 8'(op); e.o1 = 2'(o1); e.o2 = 2'(o2);
        e.md = 2'(md); e.ill = 2'(ill);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_a(input logic lv, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [6:0] f7, input exp_t e);
        int n = 0;
        ifa.in_valid = 1'b1; ifa.in_lane_valid = lv;
        ifa.in_opcode = opc; ifa.in_funct3 = f3; ifa.in_funct7 = f7;
        @(negedge clk);
        while (!ifa.in_ready && n < 50) begin @(negedge clk); n++; end
        if (!ifa.in_ready) begin
            tests++; fails++;
            $display("FAIL a_accept_timeout: in_ready stuck at 0");
        end else begin
            @(posedge clk);
            qa.push_back(e);
        end
        #1 ifa.in_valid = 1'b0;
    endtask

    task automatic push_b(input logic [1:0] lv, input logic [13:0] opc, input logic [5:0] f3,
                          input logic [13:0] f7, input exp_t e);
        int n = 0;
        ifb.in_valid = 1'b1; ifb.in_lane_valid = lv;
        ifb.in_opcode = opc; ifb.in_funct3 = f3; ifb.in_funct7 = f7;
        @(negedge clk);
        while (!ifb.in_ready && n < 50) begin @(negedge clk); n++; end
        if (!ifb.in_ready) begin
            tests++; fails++;
            $display("FAIL b_accept_timeout: in_ready stuck at 0");
        end else begin
            @(posedge clk);
            qb.push_back(e);
        end
        #1 ifb.in_valid = 1'b0;
    endtask

    // Monitor A: pop/compare on each transfer, check stability while stalled.
    exp_t hold_a;
    logic hold_a_v = 1'b0;
    always @(negedge clk) begin
        exp_t act, e;
        act = '0;
        act.lv  = 2'(ifa.out_lane_valid);
        act.op  = 8'(ifa.out_exec_op);
        act.o1  = 2'(ifa.out_op1_sel);
        act.o2  = 2'(ifa.out_op2_sel);
        act.md  = 2'(ifa.out_muldiv);
        act.ill = 2'(ifa.out_illegal);
        if (reset_n && ifa.out_valid) begin
            if (hold_a_v) chk("a_stable", 32'(act), 32'(hold_a));
            if (ifa.out_ready) begin
                if (qa.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL a_unexpected_out: got %0h expected none", act);
                end else begin
                    e = qa.pop_front();
                    chk("a_out", 32'(act), 32'(e));
                end
                hold_a_v = 1'b0;
            end else begin
                hold_a   = act;
                hold_a_v = 1'b1;
            end
        end else begin
            hold_a_v = 1'b0;
        end
    end

    // Monitor B: pop/compare on each transfer.
    always @(negedge clk) begin
        exp_t act, e;
        act.lv = ifb.out_lane_valid; act.op = ifb.out_exec_op;
        act.o1 = ifb.out_op1_sel; act.o2 = ifb.out_op2_sel;
        act.md = ifb.out_muldiv; act.ill = ifb.out_illegal;
        if (reset_n && ifb.out_valid && ifb.out_ready) begin
            if (qb.size() == 0) begin
                tests++; fails++;
                $display("FAIL b_unexpected_out: got %0h expected none", act);
            end else begin
                e = qb.pop_front();
                chk("b_out", 32'(act), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.in_valid = 0; ifa.in_lane_valid = '0; ifa.in_opcode = '0;
        ifa.in_funct3 = '0; ifa.in_funct7 = '0; ifa.out_ready = 1'b1;
        ifb.in_valid = 0; ifb.in_lane_valid = '0; ifb.in_opcode = '0;
        ifb.in_funct3 = '0; ifb.in_funct7 = '0; ifb.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid_a", 32'(ifa.out_valid), 0);
        chk("rst_in_ready_a", 32'(ifa.in_ready), 1);
        chk("rst_exec_op_a", 32'(ifa.out_exec_op), 0);
        chk("rst_cnt_a", 32'(cnt_a), 0);
        reset_n = 1'b1;
        tick();

        // Single-lane decode vectors.
        push_a(1'b1, OP,  3'b000, 7'b0100000, mk(1, 8'h8, 0, 0, 0, 0));
        push_a(1'b1, OP,  3'b001, 7'b0000001, mk(1, 8'h1, 0, 0, 1, 0));
        push_a(1'b1, IMM, 3'b101, 7'b0100000, mk(1, 8'hd, 0, 1, 0, 0));
        push_a(1'b1, IMM, 3'b001, 7'b0100000, mk(1, 0, 0, 1, 0, 1));
        chk("cnt_a_after_imm_ill", 32'(cnt_a), 1);
        push_a(1'b1, OP,  3'b010, 7'b0100000, mk(1, 0, 0, 0, 0, 1));
        chk("cnt_a_after_op_ill", 32'(cnt_a), 2);
        push_a(1'b1, LD,  3'b000, 7'b0000000, mk(1, 0, 0, 1, 0, 0));
        push_a(1'b1, BR,  3'b001, 7'b0000000, mk(1, 0, 1, 1, 0, 0));
        push_a(1'b0, OP,  3'b010, 7'b0100000, mk(0, 0, 0, 0, 0, 0));
        chk("cnt_a_masked_lane", 32'(cnt_a), 2);
        push_a(1'b1, OP,  3'b101, 7'b0100000, mk(1, 8'hd, 0, 0, 0, 0));
        push_a(1'b1, IMM, 3'b000, 7'b1111111, mk(1, 0, 0, 1, 0, 0));
        push_a(1'b1, OP,  3'b111, 7'b0000000, mk(1, 7, 0, 0, 0, 0));

        // Two-lane bundles, M disabled.
        push_b(2'b01, {OP, OP}, {3'b000, 3'b001}, {7'b0, 7'b0000001}, mk(1, 0, 0, 0, 0, 1));
        chk("cnt_b_m_disabled", 32'(cnt_b), 1);
        push_b(2'b11, {OP, JAL}, {3'b000, 3'b000}, {7'b0100000, 7'b0}, mk(3, 8'h80, 1, 1, 0, 0));
        chk("cnt_b_legal_bundle", 32'(cnt_b), 1);
        tick(); tick();

        // Skid: two JALs stall, third held until out_ready rises.
        ifa.out_ready = 1'b0;
        push_a(1'b1, JAL, 3'b000, 7'b0, mk(1, 0, 1, 1, 0, 0));
        push_a(1'b1, JAL, 3'b000, 7'b0, mk(1, 0, 1, 1, 0, 0));
        chk("skid_full_in_ready", 32'(ifa.in_ready), 0);
        chk("skid_full_out_valid", 32'(ifa.out_valid), 1);
        fork
            push_a(1'b1, OP, 3'b000, 7'b0100000, mk(1, 8'h8, 0, 0, 0, 0));
            begin
                repeat (2) begin
                    @(negedge clk);
                    chk("skid_third_held", 32'(ifa.in_ready), 0);
                end
                @(posedge clk);
                #1 ifa.out_ready = 1'b1;
            end
        join
        tick(); tick();

        // Ordering through the skid with distinct ops.
        ifa.out_ready = 1'b0;
        push_a(1'b1, OP, 3'b111, 7'b0, mk(1, 7, 0, 0, 0, 0));
        push_a(1'b1, OP, 3'b100, 7'b0, mk(1, 4, 0, 0, 0, 0));
        tick();
        ifa.out_ready = 1'b1;
        tick(); tick(); tick();

        // Flush with skid full and an illegal bundle presented.
        ifa.out_ready = 1'b0;
        push_a(1'b1, JAL, 3'b000, 7'b0, mk(1, 0, 1, 1, 0, 0));
        push_a(1'b1, OP,  3'b100, 7'b0, mk(1, 4, 0, 0, 0, 0));
        ifa.in_valid = 1'b1; ifa.in_lane_valid = 1'b1;
        ifa.in_opcode = IMM; ifa.in_funct3 = 3'b001; ifa.in_funct7 = 7'b0100000;
        flush_a = 1'b1;
        @(posedge clk);
        qa.delete();
        #1 flush_a = 1'b0;
        ifa.in_valid = 1'b0;
        chk("flush_full_out_valid", 32'(ifa.out_valid), 0);
        chk("flush_full_in_ready", 32'(ifa.in_ready), 1);
        chk("flush_full_cnt", 32'(cnt_a), 2);

        // Flush with empty stage: acceptable illegal input is dropped, not counted.
        ifa.in_valid = 1'b1;
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        ifa.in_valid = 1'b0;
        chk("flush_empty_out_valid", 32'(ifa.out_valid), 0);
        chk("flush_empty_cnt", 32'(cnt_a), 2);
        ifa.out_ready = 1'b1;
        tick();

        // Reset mid-transfer.
        ifa.out_ready = 1'b0;
        push_a(1'b1, LD, 3'b000, 7'b0, mk(1, 0, 0, 1, 0, 0));
        chk("pre_reset_out_valid", 32'(ifa.out_valid), 1);
        reset_n = 1'b0;
        #1;
        qa.delete();
        chk("midrst_out_valid_a", 32'(ifa.out_valid), 0);
        chk("midrst_cnt_a", 32'(cnt_a), 0);
        chk("midrst_cnt_b", 32'(cnt_b), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        ifa.out_ready = 1'b1;
        tick();

        // Saturation with a 2-bit counter, two illegal lanes per bundle.
        push_b(2'b11, {IMM, IMM}, {3'b001, 3'b001}, {7'b0100000, 7'b0100000}, mk(3, 0, 0, 3, 0, 3));
        chk("sat_cnt_1", 32'(cnt_b), 2);
        push_b(2'b11, {IMM, IMM}, {3'b001, 3'b001}, {7'b0100000, 7'b0100000}, mk(3, 0, 0, 3, 0, 3));
        chk("sat_cnt_2", 32'(cnt_b), 3);
        push_b(2'b11, {IMM, IMM}, {3'b001, 3'b001}, {7'b0100000, 7'b0100000}, mk(3, 0, 0, 3, 0, 3));
        chk("sat_cnt_3", 32'(cnt_b), 3);
        tick(); tick(); tick();

        chk("qa_drained", 32'(qa.size()), 0);
        chk("qb_drained", 32'(qb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
